// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and constants for the register-file write arbiter
package rf_arb_pkg;

    localparam int RF_AWIDTH = 5;
    localparam int RF_DWIDTH = 32;
    localparam int REG_ZERO  = 0;

    typedef struct packed {
        logic [RF_AWIDTH-1:0] addr;
        logic [RF_DWIDTH-1:0] data;
    } rf_entry_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// rtl/rf_arb_fifo.sv - small count-based FIFO holding long-latency results
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int WIDTH = RF_AWIDTH + RF_DWIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents are don't-care until written so it has no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the register-file write port between writeback and long-latency results
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DWIDTH = RF_DWIDTH,
    parameter int AWIDTH = RF_AWIDTH,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [AWIDTH-1:0] wb_addr,
    input  logic [DWIDTH-1:0] wb_data,
    input  logic              lu_issue,
    input  logic [AWIDTH-1:0] lu_issue_rd,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [AWIDTH-1:0] lu_addr,
    input  logic [DWIDTH-1:0] lu_data,
    input  logic [AWIDTH-1:0] q_rs1,
    input  logic [AWIDTH-1:0] q_rs2,
    input  logic [AWIDTH-1:0] q_rd,
    output logic              stall,
    output logic              rf_we,
    output logic [AWIDTH-1:0] rf_wa,
    output logic [DWIDTH-1:0] rf_wd
);

    localparam int EW   = AWIDTH + DWIDTH;
    localparam int NREG = 2 ** AWIDTH;
    localparam logic [AWIDTH-1:0] ZERO_ADDR = AWIDTH'(REG_ZERO);

    logic              slot_busy;
    logic              drain;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [EW-1:0]     head;
    logic [AWIDTH-1:0] head_addr;
    logic [DWIDTH-1:0] head_data;
    logic [NREG-1:0]   sb;
    logic [NREG-1:0]   sb_next;

    // A writeback to x0 is discarded, so it leaves the slot free for a drain.
    assign slot_busy = wb_we & (wb_addr != ZERO_ADDR);
    assign drain     = rst & ~slot_busy & ~fifo_empty;

    // Ready depends only on pre-pop occupancy, so there is no pop-to-ready path.
    assign lu_ready  = rst & ~fifo_full;
    assign push      = lu_valid & lu_ready & (lu_addr != ZERO_ADDR);

    assign head_addr = head[EW-1 -: AWIDTH];
    assign head_data = head[DWIDTH-1:0];

    assign rf_we = rst & (slot_busy | drain);
    assign rf_wa = drain ? head_addr : wb_addr;
    assign rf_wd = drain ? head_data : wb_data;

    // Full also stalls decode so no new long-latency op can overrun the queue.
    assign stall = rst & (sb[q_rs1] | sb[q_rs2] | sb[q_rd] | fifo_full);

    rf_arb_fifo #(
        .WIDTH (EW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({lu_addr, lu_data}),
        .pop   (drain),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Scoreboard update: clear on drain first, then a new issue re-sets the bit.
    always_comb begin
        sb_next = sb;
        if (drain) begin
            sb_next[head_addr] = 1'b0;
        end
        if (lu_issue && (lu_issue_rd != ZERO_ADDR)) begin
            sb_next[lu_issue_rd] = 1'b1;
        end
        sb_next[ZERO_ADDR] = 1'b0;
    end

    // Scoreboard register; reset discards every pending destination.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

endmodule
